// File: rtl/motor_mix_scheduler.sv
// Quad-X motor mix scheduler with ESC arm sequencing; optional FAILSAFE_TIMEOUT_EN receiver-loss disarm.
// Latency: duties update and duty_valid pulses 6 cycles after an accepted frame_tick.
// Backpressure: none; frame_tick while busy is dropped and reported on frame_overrun.
module motor_mix_scheduler #(
    parameter logic [7:0] DUTY_BASE  = 8'h32,
    parameter logic [7:0] DUTY_MAX   = 8'h64,
    parameter int         ARM_FRAMES = 8,
    parameter int         FS_FRAMES  = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       arm_req,
    input  logic       rx_valid,
    input  logic [7:0] throttle_offset,
    input  logic [7:0] pitch_offset,
    input  logic [7:0] roll_offset,
    input  logic [7:0] yaw_offset,
    output logic [7:0] motor0_duty,
    output logic [7:0] motor1_duty,
    output logic [7:0] motor2_duty,
    output logic [7:0] motor3_duty,
    output logic       duty_valid,
    output logic       armed,
    output logic       busy,
    output logic       frame_overrun
);
    typedef enum logic [1:0] {M_IDLE, M_SUM, M_UPDATE} mix_state_t;
    typedef enum logic [1:0] {DISARMED, ARMING, ARMED} arm_state_t;

    localparam logic signed [10:0] BASE11  = 11'(DUTY_BASE);
    localparam logic signed [10:0] MAX11   = 11'(DUTY_MAX);
    localparam logic [7:0]         ARM_CNT = 8'(ARM_FRAMES);

    mix_state_t mix_state;
    arm_state_t arm_state;
    logic [1:0] m_idx;
    logic [7:0] thr_q, p_q, r_q, y_q;
    logic [7:0] stage [4];
    logic [7:0] arm_cnt;
    logic       accepted;
    logic       arm_ok;

    assign accepted = frame_tick && (mix_state == M_IDLE);
    assign busy     = (mix_state != M_IDLE);
    assign armed    = (arm_state == ARMED);

`ifdef FAILSAFE_TIMEOUT_EN
    localparam logic [7:0] FS_CNT = 8'(FS_FRAMES);
    logic [7:0] fs_cnt;
    logic       fs_lock;

    // Once tripped, the lock holds until the pilot drops arm_req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fs_cnt  <= '0;
            fs_lock <= 1'b0;
        end else begin
            if (rx_valid)
                fs_cnt <= '0;
            else if (accepted && fs_cnt != FS_CNT)
                fs_cnt <= fs_cnt + 8'd1;
            if (fs_cnt == FS_CNT)
                fs_lock <= 1'b1;
            else if (!arm_req)
                fs_lock <= 1'b0;
        end
    end
    assign arm_ok = arm_req && !fs_lock && (fs_cnt != FS_CNT);
`else
    logic unused_rx_valid;
    assign unused_rx_valid = rx_valid;
    assign arm_ok          = arm_req;
`endif

    // Shared adder: sign pattern selected by the motor index being computed.
    logic signed [10:0] p_ext, r_ext, y_ext, sum;
    logic              neg_p, neg_r, neg_y;
    logic [7:0]        clamped;

    always_comb begin
        p_ext   = {{3{p_q[7]}}, p_q};
        r_ext   = {{3{r_q[7]}}, r_q};
        y_ext   = {{3{y_q[7]}}, y_q};
        neg_p   = (m_idx == 2'd2) || (m_idx == 2'd3);
        neg_r   = (m_idx == 2'd0) || (m_idx == 2'd3);
        neg_y   = (m_idx == 2'd1) || (m_idx == 2'd3);
        sum     = BASE11 + {3'b000, thr_q}
                + (neg_p ? -p_ext : p_ext)
                + (neg_r ? -r_ext : r_ext)
                + (neg_y ? -y_ext : y_ext);
        clamped = sum[7:0];
        if (sum < BASE11)
            clamped = DUTY_BASE;
        else if (sum > MAX11)
            clamped = DUTY_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_state     <= M_IDLE;
            m_idx         <= 2'd0;
            thr_q         <= '0;
            p_q           <= '0;
            r_q           <= '0;
            y_q           <= '0;
            for (int i = 0; i < 4; i++) stage[i] <= DUTY_BASE;
            motor0_duty   <= DUTY_BASE;
            motor1_duty   <= DUTY_BASE;
            motor2_duty   <= DUTY_BASE;
            motor3_duty   <= DUTY_BASE;
            duty_valid    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            duty_valid    <= 1'b0;
            frame_overrun <= frame_tick && (mix_state != M_IDLE);
            case (mix_state)
                M_IDLE: if (frame_tick) begin
                    thr_q     <= throttle_offset;
                    p_q       <= pitch_offset;
                    r_q       <= roll_offset;
                    y_q       <= yaw_offset;
                    m_idx     <= 2'd0;
                    mix_state <= M_SUM;
                end
                M_SUM: begin
                    stage[m_idx] <= clamped;
                    m_idx        <= m_idx + 2'd1;
                    if (m_idx == 2'd3)
                        mix_state <= M_UPDATE;
                end
                M_UPDATE: begin
                    // Anything short of fully armed keeps the ESCs at idle duty.
                    motor0_duty <= armed ? stage[0] : DUTY_BASE;
                    motor1_duty <= armed ? stage[1] : DUTY_BASE;
                    motor2_duty <= armed ? stage[2] : DUTY_BASE;
                    motor3_duty <= armed ? stage[3] : DUTY_BASE;
                    duty_valid  <= 1'b1;
                    mix_state   <= M_IDLE;
                end
                default: mix_state <= M_IDLE;
            endcase
        end
    end

    // ARMED is entered on the frame's update edge so the final arming frame still outputs idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_state <= DISARMED;
            arm_cnt   <= '0;
        end else if (!arm_ok) begin
            arm_state <= DISARMED;
            arm_cnt   <= '0;
        end else begin
            case (arm_state)
                DISARMED: if (accepted) begin
                    arm_state <= ARMING;
                    arm_cnt   <= 8'd1;
                end
                ARMING: begin
                    if (accepted && arm_cnt != ARM_CNT)
                        arm_cnt <= arm_cnt + 8'd1;
                    if (mix_state == M_UPDATE && arm_cnt == ARM_CNT)
                        arm_state <= ARMED;
                end
                ARMED:    arm_state <= ARMED;
                default:  arm_state <= DISARMED;
            endcase
        end
    end
endmodule
